// File: rtl/spiker_adapter_pkg.sv
// Shared types and sizing helpers for the spiker input loader slice.
package spiker_adapter_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LOADED  = 2'd1,
        ARM     = 2'd2,
        PRESENT = 2'd3
    } loader_state_e;

    function automatic int n_words(input int n_spikes, input int width);
        return (n_spikes + width - 1) / width;
    endfunction

endpackage

// File: rtl/spiker_input_loader_if.sv
// Register-file / core facing signal bundle of the spiker input loader.
// The loader takes the slave side; the software/register driver takes the master side.
interface spiker_input_loader_if
#(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784
) ();
    import spiker_adapter_pkg::*;

    localparam int N_WORDS = n_words(N_SPIKES, WIDTH);
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    logic                word_wr_i;
    logic [WIDTH-1:0]    word_data_i;
    logic                start_i;
    logic                clear_i;
    logic [7:0]          repeat_i;
    logic                writer_ready_i;
    logic                core_ready_i;
    logic [N_SPIKES-1:0] spikes_o;
    logic                spikes_valid_o;
    logic                loaded_o;
    logic                busy_o;
    logic                done_o;
    logic [CNT_W-1:0]    fill_cnt_o;
    logic                err_o;

    modport slave (
        input  word_wr_i, word_data_i, start_i, clear_i, repeat_i, writer_ready_i, core_ready_i,
        output spikes_o, spikes_valid_o, loaded_o, busy_o, done_o, fill_cnt_o, err_o
    );

    modport master (
        output word_wr_i, word_data_i, start_i, clear_i, repeat_i, writer_ready_i, core_ready_i,
        input  spikes_o, spikes_valid_o, loaded_o, busy_o, done_o, fill_cnt_o, err_o
    );

endinterface

// File: rtl/spiker_word_packer.sv
// Spike buffer assembled word by word, LSW first, with write pointer and flush.
module spiker_word_packer
    import spiker_adapter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    parameter int N_WORDS  = 25,
    parameter int CNT_W    = $clog2(N_WORDS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear,
    input  logic                ptr_clr,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [N_SPIKES-1:0] buf_data,
    output logic [CNT_W-1:0]    ptr
);

    logic [N_SPIKES-1:0] buf_r;
    logic [CNT_W-1:0]    ptr_r;

    // Each buffer bit belongs to word i/WIDTH; bits beyond N_SPIKES simply have no home.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_r <= '0;
        end else if (clear) begin
            buf_r <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_SPIKES; i++) begin
                if (ptr_r == CNT_W'(i / WIDTH)) begin
                    buf_r[i] <= wr_data[i % WIDTH];
                end
            end
        end
    end

    // Write pointer doubles as the fill count; the buffer survives a pointer rewind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else if (clear || ptr_clr) begin
            ptr_r <= '0;
        end else if (wr_en) begin
            ptr_r <= ptr_r + CNT_W'(1);
        end
    end

    assign buf_data = buf_r;
    assign ptr      = ptr_r;

endmodule

// File: rtl/spiker_input_loader.sv
// Spiker input loader: fills the spike vector from software words and offers it to the core.
// Optional multi-presentation mode: define SPIKER_LOADER_REPEAT_EN.
module spiker_input_loader
    import spiker_adapter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    parameter int N_WORDS  = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spiker_input_loader_if.slave  bus
);

    localparam int CNT_W = $clog2(N_WORDS + 1);

    localparam logic [1:0] ST_FILL    = FILL;
    localparam logic [1:0] ST_LOADED  = LOADED;
    localparam logic [1:0] ST_ARM     = ARM;
    localparam logic [1:0] ST_PRESENT = PRESENT;

    if (N_WORDS != n_words(N_SPIKES, WIDTH)) begin : g_bad_n_words
        $error("N_WORDS must equal ceil(N_SPIKES/WIDTH)");
    end

    logic [1:0]          state_r, state_nxt_s;
    logic                valid_r, loaded_r, busy_r, done_r, err_r;
    logic                err_nxt_s, done_nxt_s;
    logic                wr_en_s, ptr_clr_s;
    logic [N_SPIKES-1:0] spikes_s;
    logic [CNT_W-1:0]    fill_cnt_s;

`ifdef SPIKER_LOADER_REPEAT_EN
    logic [7:0]          rep_r, rep_nxt_s;
`else
    logic [7:0]          unused_repeat_s;
    assign unused_repeat_s = bus.repeat_i;
`endif

    spiker_word_packer #(
        .WIDTH    (WIDTH),
        .N_SPIKES (N_SPIKES),
        .N_WORDS  (N_WORDS),
        .CNT_W    (CNT_W)
    ) u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (bus.clear_i),
        .ptr_clr  (ptr_clr_s),
        .wr_en    (wr_en_s),
        .wr_data  (bus.word_data_i),
        .buf_data (spikes_s),
        .ptr      (fill_cnt_s)
    );

    // Next-state logic; clear overrides everything and swallows coincident strobes silently.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err_r;
        done_nxt_s  = 1'b0;
        wr_en_s     = 1'b0;
        ptr_clr_s   = 1'b0;
`ifdef SPIKER_LOADER_REPEAT_EN
        rep_nxt_s   = rep_r;
`endif
        if (bus.clear_i) begin
            state_nxt_s = ST_FILL;
            err_nxt_s   = 1'b0;
`ifdef SPIKER_LOADER_REPEAT_EN
            rep_nxt_s   = 8'd0;
`endif
        end else begin
            if ((bus.word_wr_i && (state_r != ST_FILL)) || (bus.start_i && (state_r != ST_LOADED))) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
            case (state_r)
                ST_FILL: begin
                    if (bus.word_wr_i) begin
                        wr_en_s = 1'b1;
                        if (fill_cnt_s == CNT_W'(N_WORDS - 1)) begin
                            state_nxt_s = ST_LOADED;
                        end else begin
                            state_nxt_s = ST_FILL;
                        end
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_LOADED: begin
                    if (bus.start_i) begin
                        state_nxt_s = ST_ARM;
`ifdef SPIKER_LOADER_REPEAT_EN
                        rep_nxt_s   = bus.repeat_i;
`endif
                    end else begin
                        state_nxt_s = ST_LOADED;
                    end
                end
                ST_ARM: begin
                    if (bus.writer_ready_i) begin
                        state_nxt_s = ST_PRESENT;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_PRESENT: begin
                    if (bus.core_ready_i) begin
`ifdef SPIKER_LOADER_REPEAT_EN
                        if (rep_r == 8'd0) begin
                            state_nxt_s = ST_FILL;
                            done_nxt_s  = 1'b1;
                            ptr_clr_s   = 1'b1;
                        end else begin
                            state_nxt_s = ST_PRESENT;
                            rep_nxt_s   = rep_r - 8'd1;
                        end
`else
                        state_nxt_s = ST_FILL;
                        done_nxt_s  = 1'b1;
                        ptr_clr_s   = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_PRESENT;
                    end
                end
                default: begin
                    state_nxt_s = ST_FILL;
                end
            endcase
        end
    end

    // State plus status flags, all registered from the next state so outputs are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_FILL;
            valid_r  <= 1'b0;
            loaded_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            valid_r  <= (state_nxt_s == ST_PRESENT);
            loaded_r <= (state_nxt_s == ST_LOADED);
            busy_r   <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_PRESENT);
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

`ifdef SPIKER_LOADER_REPEAT_EN
    // Remaining extra presentations for the current launch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep_r <= 8'd0;
        end else begin
            rep_r <= rep_nxt_s;
        end
    end
`endif

    assign bus.spikes_o       = spikes_s;
    assign bus.spikes_valid_o = valid_r;
    assign bus.loaded_o       = loaded_r;
    assign bus.busy_o         = busy_r;
    assign bus.done_o         = done_r;
    assign bus.fill_cnt_o     = fill_cnt_s;
    assign bus.err_o          = err_r;

endmodule
